alu_sweep_checker: RTL and testbench

Self-checking exhaustive sweep engine for the 4-bit ALU. It drives every {opcode, A, B} combination into an external ALU instance and checks the returned result and zero flag against an internal golden model. It accumulates mismatch statistics per opcode and captures the first failing vector. It wraps directly around the ALU: it is the ALU's operand source and the consumer of its outputs, and it is used to score mutated ALU variants.

---
 rtl/alu_sweep_checker.sv | 145 ++++++++++++++
 tb/tb_alu_sweep_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_sweep_checker
// Purpose  : Exhaustive sweep engine for a 4-bit ALU. It drives every
//            {op, a, b} vector, one per cycle, into an external ALU. It checks
//            the ALU's result and zero flag against an internal golden model
//            and keeps per-opcode mismatch statistics plus the first failing
//            vector.
// Ports    : clk, rst_n          clock, async active-low reset
//            start              sweep request (honoured in IDLE/DONE only)
//            alu_a/alu_b/alu_op operands/opcode driven to the ALU
//            alu_result/alu_zero combinational ALU response
//            busy, done         sweep status
//            mismatch_count     counted mismatches (CNT_W bits)
//            op_fail            per-opcode sticky failure flags
//            first_fail_*       capture of the first counted mismatch
// Revision : 1.0 - initial release
// ============================================================================
module alu_sweep_checker #(
  parameter logic [7:0] OP_MASK = 8'hFF,
  parameter int         CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [7:0]       op_fail,
  output logic             first_fail_valid,
  output logic [10:0]      first_fail_vec,
  output logic [3:0]       first_fail_result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [10:0] r_index;

  logic [2:0]  w_op;
  logic [3:0]  w_a;
  logic [3:0]  w_b;
  logic [3:0]  w_golden;
  logic        w_golden_zero;
  logic        w_mismatch;
  logic        w_count_en;
  logic        w_enter_run;
  logic        w_last;

  // The vector index is the ALU stimulus: b fastest, then a, then op.
  assign w_op   = r_index[10:8];
  assign w_a    = r_index[7:4];
  assign w_b    = r_index[3:0];
  assign alu_op = w_op;
  assign alu_a  = w_a;
  assign alu_b  = w_b;

  assign w_enter_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last      = (r_index == 11'h7FF);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // ---------------------------------------------------------- golden model
  always_comb begin
    w_golden = 4'd0;
    case (w_op)
      3'd0:    w_golden = w_a + w_b;
      3'd1:    w_golden = w_a - w_b;
      3'd2:    w_golden = w_a & w_b;
      3'd3:    w_golden = w_a | w_b;
      3'd4:    w_golden = w_a ^ w_b;
      3'd5:    w_golden = {3'd0, (w_a == w_b)};
      3'd6:    w_golden = {3'd0, (w_a < w_b)};
      default: w_golden = 4'd0;
    endcase
  end

  assign w_golden_zero = (w_golden == 4'd0);
  // A vector wrong in both result and flag is still a single mismatch.
  assign w_mismatch    = (alu_result != w_golden) || (alu_zero != w_golden_zero);
  assign w_count_en    = (r_state == S_RUN) && w_mismatch && OP_MASK[w_op];

  // ------------------------------------------------- index and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index           <= 11'd0;
      mismatch_count    <= '0;
      op_fail           <= 8'd0;
      first_fail_valid  <= 1'b0;
      first_fail_vec    <= 11'd0;
      first_fail_result <= 4'd0;
    end else if (w_enter_run) begin
      r_index           <= 11'd0;
      mismatch_count    <= '0;
      op_fail           <= 8'd0;
      first_fail_valid  <= 1'b0;
      first_fail_vec    <= 11'd0;
      first_fail_result <= 4'd0;
    end else if (r_state == S_RUN) begin
      // Natural 11-bit wrap returns the index to vector 0 on the last check.
      r_index <= r_index + 11'd1;
      if (w_count_en) begin
        mismatch_count   <= mismatch_count + {{(CNT_W-1){1'b0}}, 1'b1};
        op_fail[w_op]    <= 1'b1;
        first_fail_valid <= 1'b1;
        if (!first_fail_valid) begin
          first_fail_vec    <= r_index;
          first_fail_result <= alu_result;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sweep_checker
// Purpose  : Self-checking bench. Two checker instances (full mask and 8'hF7)
//            wrap behavioural ALUs whose faults are configurable: result forced
//            to 0 per opcode, zero flag inverted per opcode. Expected
//            statistics come from a whole-sweep reference computed in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sweep_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  r_brk;
  logic [7:0]  r_zinv;

  logic [3:0]  w_a0, w_b0, w_res0, w_a1, w_b1, w_res1;
  logic [2:0]  w_op0, w_op1;
  logic        w_zero0, w_zero1;
  logic        w_busy0, w_done0, w_busy1, w_done1;
  logic [11:0] w_cnt0, w_cnt1;
  logic [7:0]  w_opf0, w_opf1;
  logic        w_fv0, w_fv1;
  logic [10:0] w_vec0, w_vec1;
  logic [3:0]  w_fres0, w_fres1;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sweep_checker #(.OP_MASK(8'hFF), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(w_a0), .alu_b(w_b0), .alu_op(w_op0),
    .alu_result(w_res0), .alu_zero(w_zero0),
    .busy(w_busy0), .done(w_done0), .mismatch_count(w_cnt0), .op_fail(w_opf0),
    .first_fail_valid(w_fv0), .first_fail_vec(w_vec0), .first_fail_result(w_fres0)
  );

  alu_sweep_checker #(.OP_MASK(8'hF7), .CNT_W(12)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_a(w_a1), .alu_b(w_b1), .alu_op(w_op1),
    .alu_result(w_res1), .alu_zero(w_zero1),
    .busy(w_busy1), .done(w_done1), .mismatch_count(w_cnt1), .op_fail(w_opf1),
    .first_fail_valid(w_fv1), .first_fail_vec(w_vec1), .first_fail_result(w_fres1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour from the opcode table, in plain integer arithmetic.
  function automatic int golden(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 16;
      1: return (a + 16 - b) % 16;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a == b) ? 1 : 0;
      6: return (a < b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Faulty ALU: {zero, result}.
  function automatic logic [4:0] alu_fn(input int op, input int a, input int b,
                                        input logic [7:0] brk, input logic [7:0] zinv);
    int r;
    r = brk[op] ? 0 : golden(op, a, b);
    return {((r == 0) ^ zinv[op]), r[3:0]};
  endfunction

  assign {w_zero0, w_res0} = alu_fn(int'(w_op0), int'(w_a0), int'(w_b0), r_brk, r_zinv);
  assign {w_zero1, w_res1} = alu_fn(int'(w_op1), int'(w_a1), int'(w_b1), r_brk, r_zinv);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-sweep expected statistics for a given opcode mask.
  task automatic model(input logic [7:0] mask, output int cnt, output logic [7:0] opf,
                       output logic fv, output logic [10:0] vec, output logic [3:0] res);
    logic [4:0] o;
    int g;
    cnt = 0; opf = 8'd0; fv = 1'b0; vec = 11'd0; res = 4'd0;
    for (int idx = 0; idx < 2048; idx++) begin
      int op, a, b;
      op = idx / 256; a = (idx / 16) % 16; b = idx % 16;
      g = golden(op, a, b);
      o = alu_fn(op, a, b, r_brk, r_zinv);
      if ((int'(o[3:0]) != g || o[4] != (g == 0)) && mask[op]) begin
        cnt++;
        opf[op] = 1'b1;
        if (!fv) begin
          fv = 1'b1; vec = idx[10:0]; res = o[3:0];
        end
      end
    end
  endtask

  task automatic check_stats();
    int c; logic [7:0] f; logic v; logic [10:0] vv; logic [3:0] rr;
    model(8'hFF, c, f, v, vv, rr);
    check("cnt_ff", 32'(w_cnt0), c);
    check("opf_ff", 32'(w_opf0), 32'(f));
    check("fv_ff", 32'(w_fv0), 32'(v));
    check("vec_ff", 32'(w_vec0), 32'(vv));
    check("fres_ff", 32'(w_fres0), 32'(rr));
    model(8'hF7, c, f, v, vv, rr);
    check("cnt_f7", 32'(w_cnt1), c);
    check("opf_f7", 32'(w_opf1), 32'(f));
    check("fv_f7", 32'(w_fv1), 32'(v));
    check("vec_f7", 32'(w_vec1), 32'(vv));
  endtask

  // Start a sweep, optionally poke start at vector 100, and measure busy length.
  task automatic run_sweep(input bit poke);
    int cycles;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("entry_busy", {w_busy0, w_done0, w_busy1}, 3'b101);
    check("entry_clr", {w_cnt0, w_opf0, w_fv0}, 0);
    check("entry_vec0", {w_op0, w_a0, w_b0}, 0);
    cycles = 0;
    while (w_busy0 && cycles < 3000) begin
      cycles++;
      start = poke && (cycles == 101);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_len", cycles, 2048);
    check("done", {w_done0, w_busy0, w_done1}, 3'b101);
    check("wrap_vec", {w_op0, w_a0, w_b0}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; r_brk = 8'h00; r_zinv = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_flags", {w_busy0, w_done0, w_fv0, w_opf0, w_op0, w_a0, w_b0}, 0);
    check("rst_stats", {w_cnt0, w_vec0, w_fres0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_hold", {w_busy0, w_done0}, 0);

    // Correct ALU.
    run_sweep(1'b0);
    check_stats();
    check("good_cnt", 32'(w_cnt0), 0);

    // SUB, OR, LT broken to 0.
    r_brk = 8'h4A;
    run_sweep(1'b0);
    check_stats();
    check("f_cnt", 32'(w_cnt0), 615);
    check("f_opf", 32'(w_opf0), 32'h4A);
    check("f_vec", 32'(w_vec0), 32'h101);
    check("fm_cnt", 32'(w_cnt1), 360);
    check("fm_opf", 32'(w_opf1), 32'h42);

    // Zero flag inverted for opcode 101 only.
    r_brk = 8'h00; r_zinv = 8'h20;
    run_sweep(1'b0);
    check_stats();
    check("z_cnt", 32'(w_cnt0), 256);
    check("z_vec", 32'(w_vec0), 32'h500);
    check("z_fres", 32'(w_fres0), 1);

    // Reset at vector 500 of a faulty sweep.
    r_zinv = 8'h00; r_brk = 8'h4A;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (500) @(negedge clk);
    check("pre_rst_idx", {w_op0, w_a0, w_b0}, 500);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {w_busy0, w_done0, w_fv0, w_opf0, w_op0, w_a0, w_b0}, 0);
    check("mid_rst_stats", {w_cnt0, w_vec0, w_fres0}, 0);
    @(negedge clk) rst_n = 1'b1;
    run_sweep(1'b0);
    check_stats();
    check("rst_f_cnt", 32'(w_cnt0), 615);

    // start pulsed mid-sweep is ignored; then a fresh good sweep from DONE.
    run_sweep(1'b1);
    check_stats();
    r_brk = 8'h00;
    run_sweep(1'b0);
    check_stats();

    // Random fault configurations.
    for (int t = 0; t < 4; t++) begin
      r_brk  = 8'($urandom) & 8'($urandom);
      r_zinv = 8'($urandom) & 8'($urandom);
      run_sweep(1'b0);
      check_stats();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
